// File: rtl/button_bounce_if.sv
// Request/status bundle between a sequencer and the bouncing-button generator.
interface button_bounce_if;
  logic req;
  logic level;
  logic buttonOut;
  logic busy;
  logic done;

  modport master (
    output req,
    output level,
    input  buttonOut,
    input  busy,
    input  done
  );

  modport slave (
    input  req,
    input  level,
    output buttonOut,
    output busy,
    output done
  );
endinterface

// File: rtl/button_bounce_gen.sv
// Bouncing button waveform generator: on a level-change request the output
// toggles through BOUNCES pseudo-random glitch pairs, then settles at the target.
//
// state  | meaning
// IDLE   | output holds last level, waiting for a level-change request
// ACT    | glitch phase at the target level
// INACT  | glitch phase back at the old level
// SETTLE | final hold at the target level, done pulses on exit
module button_bounce_gen #(
  parameter int          BOUNCES       = 5,
  parameter int          PHASE_WIDTH   = 12,
  parameter int          MIN_PHASE     = 16,
  parameter int          SETTLE_CYCLES = 40000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input logic              clk,
  input logic              rst,
  button_bounce_if.slave   bus
);

  localparam int PH_MAX  = MIN_PHASE + (1 << PHASE_WIDTH) - 1;
  localparam int CNT_MAX = (SETTLE_CYCLES > PH_MAX) ? SETTLE_CYCLES : PH_MAX;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] MIN_M1    = CW'(MIN_PHASE - 1);
  localparam logic [CW-1:0] SETTLE_M1 = CW'(SETTLE_CYCLES - 1);
  localparam logic [7:0]    BOUNCE_N  = 8'(BOUNCES);

  typedef enum logic [1:0] {IDLE, ACT, INACT, SETTLE} state_t;

  state_t        state, state_nxt;
  logic [15:0]   lfsr;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    bounce_cnt, bounce_cnt_nxt;
  logic          target, target_nxt;
  logic          button, button_nxt;
  logic          busy_r, done_r, done_nxt;
  logic [CW-1:0] phase_load;
  logic          expire;

  // Counter is loaded with L-1 so a phase of length L expires on its last cycle.
  assign phase_load = MIN_M1 + {{(CW-PHASE_WIDTH){1'b0}}, lfsr[PHASE_WIDTH-1:0]};
  assign expire     = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr       <= LFSR_SEED;
      state      <= IDLE;
      cnt        <= '0;
      bounce_cnt <= '0;
      target     <= 1'b0;
      button     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bounce_cnt <= bounce_cnt_nxt;
      target     <= target_nxt;
      button     <= button_nxt;
      busy_r     <= (state_nxt != IDLE);
      done_r     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    bounce_cnt_nxt = bounce_cnt;
    target_nxt     = target;
    button_nxt     = button;
    done_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req && (bus.level != button)) begin
          target_nxt     = bus.level;
          bounce_cnt_nxt = BOUNCE_N;
          cnt_nxt        = phase_load;
          button_nxt     = bus.level;
          state_nxt      = ACT;
        end
      end
      ACT: begin
        if (!expire) begin
          cnt_nxt = cnt - 1'b1;
        end else if (bounce_cnt == 8'd0) begin
          cnt_nxt   = SETTLE_M1;
          state_nxt = SETTLE;
        end else begin
          cnt_nxt    = phase_load;
          button_nxt = ~target;
          state_nxt  = INACT;
        end
      end
      INACT: begin
        if (!expire) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          bounce_cnt_nxt = bounce_cnt - 1'b1;
          cnt_nxt        = phase_load;
          button_nxt     = target;
          state_nxt      = ACT;
        end
      end
      SETTLE: begin
        if (!expire) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.buttonOut = button;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_button_bounce_gen.sv
// Directed bench for button_bounce_gen: phase lengths are predicted from an
// LFSR model and compared against the measured run lengths of buttonOut.
module tb_button_bounce_gen;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk;
  logic rst;

  button_bounce_if bus_a ();
  button_bounce_if bus_b ();

  button_bounce_gen #(
    .BOUNCES(5), .PHASE_WIDTH(6), .MIN_PHASE(16), .SETTLE_CYCLES(200), .LFSR_SEED(SEED)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );

  button_bounce_gen #(
    .BOUNCES(0), .PHASE_WIDTH(1), .MIN_PHASE(1), .SETTLE_CYCLES(4), .LFSR_SEED(SEED)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [15:0] m_lfsr;
  int last_runs[$];
  int ref_runs[$];

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    // x^16 + x^14 + x^13 + x^11 + 1, shifting towards the MSB
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s, input int n);
    logic [15:0] r = s;
    for (int i = 0; i < n; i++) r = lfsr_step(r);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) m_lfsr = SEED;
    else     m_lfsr = lfsr_step(m_lfsr);
    #1;
  endtask

  task automatic drv(input int sel, input logic r, input logic l);
    if (sel == 0) begin bus_a.req = r; bus_a.level = l; end
    else          begin bus_b.req = r; bus_b.level = l; end
  endtask

  function automatic logic [2:0] obs(input int sel);
    if (sel == 0) return {bus_a.buttonOut, bus_a.busy, bus_a.done};
    return {bus_b.buttonOut, bus_b.busy, bus_b.done};
  endfunction

  // Issues one request and measures the whole sequence; inj >= 0 pulses an
  // extra (to-be-ignored) request that many cycles into the sequence.
  task automatic do_seq(input int sel, input logic lvl, input int nb, input int mn,
                        input int pw, input int st, input int inj, input string nm);
    int exp_len[$];
    logic [15:0] s;
    int mask, limit, run, trans, busy_drop;
    logic prev, fin;
    logic [2:0] o;
    mask  = (1 << pw) - 1;
    s     = m_lfsr;
    limit = st + 10;
    for (int i = 0; i < 2*nb + 1; i++) begin
      int l;
      l = mn + int'(s) & mask;
      l = mn + (int'(s) & mask);
      exp_len.push_back(l);
      limit += l;
      s = lfsr_adv(s, l);
    end
    last_runs.delete();
    drv(sel, 1'b1, lvl);
    tick();
    drv(sel, 1'b0, lvl);
    prev = ~lvl; run = 0; trans = 0; busy_drop = 0; fin = 1'b0;
    for (int c = 0; c < limit && !fin; c++) begin
      o = obs(sel);
      if (c == 0) begin
        chk({nm, "_busy_rise"}, o[1], 1'b1);
        chk({nm, "_first_edge"}, o[2], lvl);
      end
      if (o[0]) begin
        fin = 1'b1;
        chk({nm, "_done_busy"}, o[1], 1'b0);
        chk({nm, "_done_level"}, o[2], lvl);
        last_runs.push_back(run);
      end else begin
        if (!o[1]) busy_drop++;
        if (o[2] != prev) begin
          trans++;
          if (run > 0) last_runs.push_back(run);
          run  = 1;
          prev = o[2];
        end else begin
          run++;
        end
      end
      if (c == inj) drv(sel, 1'b1, 1'b1);
      else          drv(sel, 1'b0, lvl);
      if (!fin) tick();
    end
    drv(sel, 1'b0, lvl);
    chk({nm, "_done_seen"}, fin, 1'b1);
    chk({nm, "_busy_held"}, busy_drop, 0);
    chk({nm, "_transitions"}, trans, 2*nb + 1);
    chk({nm, "_run_count"}, last_runs.size(), 2*nb + 1);
    if (last_runs.size() == 2*nb + 1) begin
      for (int i = 0; i < 2*nb; i++) begin
        chk($sformatf("%s_phase%0d", nm, i), last_runs[i], exp_len[i]);
        chk($sformatf("%s_range%0d", nm, i),
            (last_runs[i] >= mn && last_runs[i] <= mn + mask), 1'b1);
      end
      chk({nm, "_final_run"}, last_runs[2*nb], exp_len[2*nb] + st);
    end
    tick();
    o = obs(sel);
    chk({nm, "_done_one_cycle"}, o[0], 1'b0);
    chk({nm, "_idle_busy"}, o[1], 1'b0);
    chk({nm, "_hold_level"}, o[2], lvl);
  endtask

  initial begin
    logic [2:0] o;
    logic found;
    bus_a.req = 1'b0; bus_a.level = 1'b0;
    bus_b.req = 1'b0; bus_b.level = 1'b0;
    rst = 1'b1;

    // Reset held with requests pulsing: everything stays at zero.
    for (int i = 0; i < 3; i++) begin
      drv(0, i[0] == 1'b0, 1'b1);
      drv(1, i[0] == 1'b0, 1'b1);
      tick();
      chk("rst_a", obs(0), 3'b000);
      chk("rst_b", obs(1), 3'b000);
    end
    drv(0, 1'b0, 1'b0);
    drv(1, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // Press with an ignored request landing mid-sequence.
    do_seq(0, 1'b1, 5, 16, 6, 200, 20, "press");
    ref_runs = last_runs;

    // Same-level request in IDLE is ignored.
    drv(0, 1'b1, 1'b1);
    tick();
    drv(0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("same_level_ignored", obs(0), 3'b100);
      tick();
    end

    // Release back to 0, with a random idle gap first.
    for (int i = 0; i < int'($urandom_range(1, 9)); i++) tick();
    do_seq(0, 1'b0, 5, 16, 6, 200, -1, "release");

    // Interrupt a press during an INACT phase with reset.
    for (int i = 0; i < int'($urandom_range(1, 9)); i++) tick();
    drv(0, 1'b1, 1'b1);
    tick();
    drv(0, 1'b0, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      o = obs(0);
      if (o[2] == 1'b0 && o[1]) found = 1'b1;
      else tick();
    end
    chk("inact_reached", found, 1'b1);
    rst = 1'b1;
    tick();
    chk("midrst_outputs", obs(0), 3'b000);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("midrst_no_done", obs(0), 3'b000);
      tick();
    end
    do_seq(0, 1'b1, 5, 16, 6, 200, -1, "repeat");
    chk("repeat_count", last_runs.size(), ref_runs.size());
    if (last_runs.size() == ref_runs.size())
      for (int i = 0; i < ref_runs.size(); i++)
        chk($sformatf("repeat_run%0d", i), last_runs[i], ref_runs[i]);

    // Small build: one clean edge, 1..2 cycle ACT, 4 settle cycles.
    for (int i = 0; i < int'($urandom_range(1, 9)); i++) tick();
    do_seq(1, 1'b1, 0, 1, 1, 4, -1, "small_press");
    chk("small_total_range", (last_runs[0] >= 5 && last_runs[0] <= 6), 1'b1);
    do_seq(1, 1'b0, 0, 1, 1, 4, -1, "small_release");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
